// File: rtl/ghost_ai_modal.sv
// ghost_ai_modal: steering for one ghost. A scatter/chase/frightened mode
// sequencer picks a target tile. A two-cycle decision pipeline, started by
// tick, turns that target into one legal one-hot direction request.
module ghost_ai_modal #(
   parameter int         X_W            = 6,
   parameter int         Y_W            = 5,
   parameter int         SCATTER_X      = 0,
   parameter int         SCATTER_Y      = 0,
   parameter int         TARGET_AHEAD   = 0,
   parameter int         SCATTER_TICKS  = 420,
   parameter int         CHASE_TICKS    = 1200,
   parameter int         SCATTER_ROUNDS = 3,
   parameter int         FRIGHT_TICKS   = 360,
   parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
   input  logic           clk_25mhz,
   input  logic           reset,
   input  logic           tick,
   input  logic           energizer,
   input  logic [X_W-1:0] GhostPosition_x,
   input  logic [Y_W-1:0] GhostPosition_y,
   input  logic [X_W-1:0] PacManPosition_x,
   input  logic [Y_W-1:0] PacManPosition_y,
   input  logic [3:0]     PacManDirection,
   input  logic [3:0]     validDirection,
   input  logic [3:0]     GhostDirActual,
   output logic [3:0]     GhostDirection,
   output logic [1:0]     mode
);

   localparam int D_W    = X_W + Y_W + 1;
   localparam int T_MAX1 = (SCATTER_TICKS > CHASE_TICKS) ? SCATTER_TICKS : CHASE_TICKS;
   localparam int T_MAX  = (T_MAX1 > FRIGHT_TICKS) ? T_MAX1 : FRIGHT_TICKS;
   localparam int CNT_W  = $clog2(T_MAX + 1);
   localparam int SX_W   = X_W + 4;
   localparam int SY_W   = Y_W + 4;

   localparam logic [CNT_W-1:0]       SC_LAST  = CNT_W'(SCATTER_TICKS - 1);
   localparam logic [CNT_W-1:0]       CH_LAST  = CNT_W'(CHASE_TICKS - 1);
   localparam logic [CNT_W-1:0]       FR_LAST  = CNT_W'(FRIGHT_TICKS - 1);
   localparam logic [2:0]             ROUNDS   = 3'(SCATTER_ROUNDS);
   localparam logic signed [SX_W-1:0] X_MAX    = SX_W'((1 << X_W) - 1);
   localparam logic signed [SY_W-1:0] Y_MAX    = SY_W'((1 << Y_W) - 1);
   localparam logic signed [SX_W-1:0] X_AHEAD  = SX_W'(TARGET_AHEAD);
   localparam logic signed [SY_W-1:0] Y_AHEAD  = SY_W'(TARGET_AHEAD);

   typedef enum logic [1:0] {
      M_SCATTER = 2'd0,
      M_CHASE   = 2'd1,
      M_FRIGHT  = 2'd2
   } mode_e;

   // left<->right, up<->down
   function automatic logic [3:0] rev_dir(input logic [3:0] d);
      return {d[2], d[3], d[0], d[1]};
   endfunction

   function automatic logic one_hot(input logic [3:0] d);
      return (d != 4'b0000) && ((d & (d - 4'b0001)) == 4'b0000);
   endfunction

   function automatic logic [X_W-1:0] clamp_x(input logic signed [SX_W-1:0] v);
      if (v[SX_W-1])      return '0;
      else if (v > X_MAX) return '1;
      else                return v[X_W-1:0];
   endfunction

   function automatic logic [Y_W-1:0] clamp_y(input logic signed [SY_W-1:0] v);
      if (v[SY_W-1])      return '0;
      else if (v > Y_MAX) return '1;
      else                return v[Y_W-1:0];
   endfunction

   function automatic logic [D_W-1:0] manhattan(input logic [X_W-1:0] ax, input logic [X_W-1:0] bx,
                                                input logic [Y_W-1:0] ay, input logic [Y_W-1:0] by);
      logic [X_W-1:0] dx;
      logic [Y_W-1:0] dy;
      dx = (ax > bx) ? (ax - bx) : (bx - ax);
      dy = (ay > by) ? (ay - by) : (by - ay);
      return D_W'(dx) + D_W'(dy);
   endfunction

   // Tie-break order for equal distances: up, left, down, right
   function automatic logic [1:0] prio(input int k);
      case (k)
         0:       return 2'd2;
         1:       return 2'd0;
         2:       return 2'd3;
         default: return 2'd1;
      endcase
   endfunction

   mode_e            mode_q, mode_d, saved_mode_q, saved_mode_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, saved_cnt_q, saved_cnt_d;
   logic [2:0]       round_q, round_d;
   logic             rev_pend_q, rev_pend_d, rev_set, rev_clr;
   logic [7:0]       lfsr_q, lfsr_d;
   logic [3:0]       last_dir_q, last_dir_d;
   logic [3:0]       dir_q, dir_d;
   logic             vld_p1_q;

   logic signed [SX_W-1:0] ax_s;
   logic signed [SY_W-1:0] ay_s;
   logic [X_W-1:0]         tgt_x, nl_x, nr_x;
   logic [Y_W-1:0]         tgt_y, nu_y, nd_y;
   logic [D_W-1:0]         dist_d [4];
   logic [D_W-1:0]         dist_p1_q [4];
   logic                   fright_p1_q;
   logic [1:0]             idx_p1_q;

   logic [3:0] cand;
   logic [1:0] idx, pick;
   logic       found;
   logic       fire;

   assign mode           = mode_q;
   assign GhostDirection = dir_q;

   assign last_dir_d = one_hot(GhostDirActual) ? GhostDirActual : last_dir_q;
   assign lfsr_d     = tick ? {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]} : lfsr_q;
   assign rev_pend_d = rev_set | (rev_pend_q & ~rev_clr);
   // A newer tick in the same cycle supersedes the decision in flight
   assign fire       = vld_p1_q & ~tick;

   // Control state: mode sequencer, reverse flag, LFSR, direction history, pipeline valid, output
   always_ff @(posedge clk_25mhz) begin
      if (reset) begin
         mode_q       <= M_SCATTER;
         cnt_q        <= '0;
         round_q      <= '0;
         saved_mode_q <= M_SCATTER;
         saved_cnt_q  <= '0;
         rev_pend_q   <= 1'b0;
         lfsr_q       <= LFSR_SEED;
         last_dir_q   <= 4'b0001;
         dir_q        <= 4'b0000;
         vld_p1_q     <= 1'b0;
      end else begin
         mode_q       <= mode_d;
         cnt_q        <= cnt_d;
         round_q      <= round_d;
         saved_mode_q <= saved_mode_d;
         saved_cnt_q  <= saved_cnt_d;
         rev_pend_q   <= rev_pend_d;
         lfsr_q       <= lfsr_d;
         last_dir_q   <= last_dir_d;
         dir_q        <= dir_d;
         vld_p1_q     <= tick;
      end
   end

   // Mode sequencer next state; energizer overrides the tick step of the same cycle
   always_comb begin
      mode_d       = mode_q;
      cnt_d        = cnt_q;
      round_d      = round_q;
      saved_mode_d = saved_mode_q;
      saved_cnt_d  = saved_cnt_q;
      rev_set      = 1'b0;
      if (energizer) begin
         cnt_d = '0;
         if (mode_q != M_FRIGHT) begin
            saved_mode_d = mode_q;
            saved_cnt_d  = cnt_q;
            mode_d       = M_FRIGHT;
            rev_set      = 1'b1;
         end
      end else if (tick) begin
         case (mode_q)
            M_SCATTER: begin
               if (cnt_q == SC_LAST) begin
                  mode_d  = M_CHASE;
                  cnt_d   = '0;
                  round_d = (round_q == 3'd7) ? round_q : round_q + 3'd1;
                  rev_set = 1'b1;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            M_CHASE: begin
               if (cnt_q == CH_LAST) begin
                  if (round_q < ROUNDS) begin
                     mode_d  = M_SCATTER;
                     cnt_d   = '0;
                     rev_set = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            M_FRIGHT: begin
               if (cnt_q == FR_LAST) begin
                  mode_d = saved_mode_q;
                  cnt_d  = saved_cnt_q;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               mode_d = M_SCATTER;
               cnt_d  = '0;
            end
         endcase
      end
   end

   // Target tile and neighbour distances for the current mode
   always_comb begin
      ax_s = $signed({4'b0000, PacManPosition_x});
      ay_s = $signed({4'b0000, PacManPosition_y});
      case (PacManDirection)
         4'b0001: ax_s = ax_s - X_AHEAD;
         4'b0010: ax_s = ax_s + X_AHEAD;
         4'b0100: ay_s = ay_s - Y_AHEAD;
         4'b1000: ay_s = ay_s + Y_AHEAD;
         default: ;
      endcase
      if (mode_q == M_SCATTER) begin
         tgt_x = X_W'(SCATTER_X);
         tgt_y = Y_W'(SCATTER_Y);
      end else begin
         tgt_x = clamp_x(ax_s);
         tgt_y = clamp_y(ay_s);
      end
      dist_d[0] = manhattan(nl_x, tgt_x, GhostPosition_y, tgt_y);
      dist_d[1] = manhattan(nr_x, tgt_x, GhostPosition_y, tgt_y);
      dist_d[2] = manhattan(GhostPosition_x, tgt_x, nu_y, tgt_y);
      dist_d[3] = manhattan(GhostPosition_x, tgt_x, nd_y, tgt_y);
   end

   // Neighbour tiles wrap around the maze edge (tunnel)
   assign nl_x = GhostPosition_x - X_W'(1);
   assign nr_x = GhostPosition_x + X_W'(1);
   assign nu_y = GhostPosition_y - Y_W'(1);
   assign nd_y = GhostPosition_y + Y_W'(1);

   // Stage 1: capture distances, decision mode and the pre-shift LFSR start index
   always_ff @(posedge clk_25mhz) begin
      if (tick) begin
         dist_p1_q   <= dist_d;
         fright_p1_q <= (mode_q == M_FRIGHT);
         idx_p1_q    <= lfsr_q[1:0];
      end
   end

   // Stage 2: pick the steering direction from the captured distances
   always_comb begin
      dir_d   = dir_q;
      rev_clr = 1'b0;
      cand    = validDirection & ~rev_dir(last_dir_q);
      idx     = 2'd0;
      pick    = 2'd0;
      found   = 1'b0;
      if (fire) begin
         if (validDirection == 4'b0000) begin
            dir_d = 4'b0000;
         end else if (one_hot(validDirection)) begin
            dir_d = validDirection;
         end else if (rev_pend_q && ((validDirection & rev_dir(last_dir_q)) != 4'b0000)) begin
            dir_d   = rev_dir(last_dir_q);
            rev_clr = 1'b1;
         end else begin
            rev_clr = 1'b1;
            if (fright_p1_q) begin
               for (int k = 0; k < 4; k++) begin
                  idx = idx_p1_q + 2'(k);
                  if (!found && cand[idx]) begin
                     found = 1'b1;
                     pick  = idx;
                  end
               end
            end else begin
               for (int k = 0; k < 4; k++) begin
                  idx = prio(k);
                  if (cand[idx] && (!found || (dist_p1_q[idx] < dist_p1_q[pick]))) begin
                     found = 1'b1;
                     pick  = idx;
                  end
               end
            end
            dir_d = found ? (4'b0001 << pick) : 4'b0000;
         end
      end
   end

endmodule

// File: tb/tb_ghost_ai_modal.sv
// Directed bench for ghost_ai_modal: uA runs with a long scatter phase,
// uB with short phases, TARGET_AHEAD=4 and LFSR seed 8'h01.
module tb_ghost_ai_modal;

   logic       clk = 1'b0;
   logic       reset, tick, energizer;
   logic [5:0] gx, px;
   logic [4:0] gy, py;
   logic [3:0] pdir, valid, actual;
   logic [3:0] dirA, dirB;
   logic [1:0] modeA, modeB;

   int n_assert = 0;
   int n_fail   = 0;

   logic [3:0] exp_fr [4] = '{4'b0010, 4'b1000, 4'b0001, 4'b0001};

   always #20 clk = ~clk;

   ghost_ai_modal #(.SCATTER_TICKS(50)) uA (
      .clk_25mhz(clk), .reset(reset), .tick(tick), .energizer(energizer),
      .GhostPosition_x(gx), .GhostPosition_y(gy),
      .PacManPosition_x(px), .PacManPosition_y(py),
      .PacManDirection(pdir), .validDirection(valid), .GhostDirActual(actual),
      .GhostDirection(dirA), .mode(modeA)
   );

   ghost_ai_modal #(
      .TARGET_AHEAD(4), .SCATTER_TICKS(4), .CHASE_TICKS(6), .SCATTER_ROUNDS(1),
      .FRIGHT_TICKS(5), .LFSR_SEED(8'h01)
   ) uB (
      .clk_25mhz(clk), .reset(reset), .tick(tick), .energizer(energizer),
      .GhostPosition_x(gx), .GhostPosition_y(gy),
      .PacManPosition_x(px), .PacManPosition_y(py),
      .PacManDirection(pdir), .validDirection(valid), .GhostDirActual(actual),
      .GhostDirection(dirB), .mode(modeB)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // one tick, then one more cycle so the decision output is visible
   task automatic game_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      repeat (n) game_tick();
   endtask

   task automatic pulse_energizer();
      energizer = 1'b1;
      @(negedge clk);
      energizer = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; tick = 1'b0; energizer = 1'b0;
      gx = '0; gy = '0; px = '0; py = '0;
      pdir = 4'b0000; valid = 4'b0000; actual = 4'b0000;
      cycles(3);
      check("rst_dirA", dirA, 4'b0000);
      check("rst_modeA", modeA, 2'd0);
      check("rst_dirB", dirB, 4'b0000);
      check("rst_modeB", modeB, 2'd0);
      check("rst_lfsrB", uB.lfsr_q, 8'h01);
      check("rst_lastdir", uB.last_dir_q, 4'b0001);
      reset = 1'b0;

      // scatter decision, up beats left on a 19/19 tie
      gx = 6'd10; gy = 5'd10; valid = 4'b0101;
      game_tick();
      check("scatter_tie_up", dirA, 4'b0100);
      check("scatter_mode", modeA, 2'd0);
      cycles(3);
      check("dir_hold", dirA, 4'b0100);

      // scatter -> chase after 4 ticks, forced reversal, chase saturates
      do_reset();
      valid = 4'b0000;
      ticks(3);
      check("mode_before_switch", modeB, 2'd0);
      game_tick();
      check("mode_to_chase", modeB, 2'd1);
      check("no_exit_dir", dirB, 4'b0000);
      actual = 4'b0010; valid = 4'b1111;
      cycles(1);
      game_tick();
      check("forced_reverse", dirB, 4'b0001);
      valid = 4'b0000;
      ticks(6);
      check("chase_stays", modeB, 2'd1);

      // chase target clamps high to (63,12)
      px = 6'd60; py = 5'd12; pdir = 4'b0010;
      gx = 6'd20; gy = 5'd12; valid = 4'b1111; actual = 4'b0100;
      cycles(1);
      game_tick();
      check("chase_clamp_hi", dirB, 4'b0010);
      // clamp low: PacMan (2,12) facing left -> target (0,12)
      px = 6'd2; pdir = 4'b0001; gx = 6'd1; valid = 4'b0011;
      game_tick();
      check("chase_clamp_lo", dirB, 4'b0001);
      // non-one-hot PacMan direction -> target (2,12)
      pdir = 4'b0000;
      game_tick();
      check("chase_zero_offset", dirB, 4'b0010);

      // energizer in chase at count 3, re-energize, restore without reversal
      do_reset();
      valid = 4'b0000; actual = 4'b0000;
      ticks(4);
      ticks(3);
      check("chase_before_fright", modeB, 2'd1);
      pulse_energizer();
      check("fright_enter", modeB, 2'd2);
      actual = 4'b0010; valid = 4'b1111;
      cycles(1);
      game_tick();
      check("fright_entry_reverse", dirB, 4'b0001);
      valid = 4'b0000;
      game_tick();
      pulse_energizer();
      check("fright_restart", modeB, 2'd2);
      ticks(4);
      check("fright_tick6", modeB, 2'd2);
      game_tick();
      check("fright_exit_mode", modeB, 2'd1);
      check("fright_exit_count", uB.cnt_q, 3);
      px = 6'd40; py = 5'd10; pdir = 4'b0000;
      gx = 6'd10; gy = 5'd10; valid = 4'b1111;
      game_tick();
      check("no_reverse_after_exit", dirB, 4'b0010);

      // frightened pseudo-random walk from seed 8'h01
      do_reset();
      valid = 4'b0000; actual = 4'b1000;
      cycles(1);
      pulse_energizer();
      valid = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         game_tick();
         check($sformatf("fright_walk%0d", i), dirB, exp_fr[i]);
         check($sformatf("fright_no_up%0d", i), dirB[2], 1'b0);
      end
      check("fright_walk_mode", modeB, 2'd2);

      // tunnel edge, single exit that is also the reverse
      do_reset();
      gx = 6'd0; gy = 5'd10; valid = 4'b0001; actual = 4'b0010;
      cycles(1);
      game_tick();
      check("tunnel_single_exit", dirB, 4'b0001);
      check("tunnel_mode", modeB, 2'd0);
      // tick and energizer together: energizer wins, tick step dropped
      tick = 1'b1; energizer = 1'b1;
      @(negedge clk);
      tick = 1'b0; energizer = 1'b0;
      @(negedge clk);
      check("tick_energizer_mode", modeB, 2'd2);
      check("tick_energizer_cnt", uB.cnt_q, 0);
      check("tick_energizer_saved", uB.saved_cnt_q, 1);
      check("tick_energizer_dir", dirB, 4'b0001);

      // reset aborts an in-flight decision
      valid = 4'b0010;
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0; reset = 1'b1;
      @(negedge clk);
      check("abort_dir", dirB, 4'b0000);
      check("abort_mode", modeB, 2'd0);
      reset = 1'b0;
      @(negedge clk);
      check("abort_no_late_dir", dirB, 4'b0000);

      // back-to-back ticks: only the latest decision lands
      valid = 4'b0001;
      tick = 1'b1;
      @(negedge clk);
      valid = 4'b0100;
      @(negedge clk);
      tick = 1'b0;
      check("restart_drop", dirB, 4'b0000);
      @(negedge clk);
      check("restart_latest", dirB, 4'b0100);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
